uart_cmd_decoder: RTL

Byte-stream command decoder sitting directly downstream of the UART receiver in the DIF slow-control path. It consumes received bytes (8-bit data plus a one-cycle valid pulse) and assembles fixed 5-byte frames: header, address, data high, data low, XOR checksum. Each good frame becomes a single-cycle register-write command. Malformed or stalled frames are dropped and counted.

---
 rtl/uart_cmd_decoder_if.sv | 21 ++
 rtl/uart_cmd_decoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder_if.sv
// rtl/uart_cmd_decoder_if.sv - byte-in / command-out bundle for the UART command decoder
interface uart_cmd_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        busy;
    logic [7:0]  err_cnt;
    logic        err_flag;

    modport master (
        output rx_data, rx_valid,
        input  cmd_addr, cmd_data, cmd_valid, busy, err_cnt, err_flag
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd_addr, cmd_data, cmd_valid, busy, err_cnt, err_flag
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - assembles 5-byte UART frames into register-write commands
module uart_cmd_decoder #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 21000
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_cmd_decoder_if.slave bus
);

    localparam int unsigned   TW         = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        DHI,
        DLO,
        CSUM
    } state_t;

    state_t      state;
    logic [TW-1:0] timer;
    logic [7:0]  addr_buf;
    logic [7:0]  dhi_buf;
    logic [7:0]  dlo_buf;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        busy;
    logic [7:0]  err_cnt;
    logic        err_flag;

    logic        csum_ok;
    logic [7:0]  err_cnt_next;

    assign csum_ok      = (bus.rx_data == (addr_buf ^ dhi_buf ^ dlo_buf));
    assign err_cnt_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            timer     <= '0;
            addr_buf  <= '0;
            dhi_buf   <= '0;
            dlo_buf   <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            err_flag  <= 1'b0;
            if (bus.rx_valid) begin
                // A byte always beats a coinciding timeout.
                timer <= '0;
                case (state)
                    HUNT: begin
                        if (bus.rx_data == HEADER) begin
                            state <= ADDR;
                            busy  <= 1'b1;
                        end
                    end
                    ADDR: begin
                        addr_buf <= bus.rx_data;
                        state    <= DHI;
                    end
                    DHI: begin
                        dhi_buf <= bus.rx_data;
                        state   <= DLO;
                    end
                    DLO: begin
                        dlo_buf <= bus.rx_data;
                        state   <= CSUM;
                    end
                    CSUM: begin
                        state <= HUNT;
                        busy  <= 1'b0;
                        if (csum_ok) begin
                            cmd_addr  <= addr_buf;
                            cmd_data  <= {dhi_buf, dlo_buf};
                            cmd_valid <= 1'b1;
                        end else begin
                            err_flag <= 1'b1;
                            err_cnt  <= err_cnt_next;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (state == HUNT) begin
                timer <= '0;
            end else if (timer == TIMER_LAST) begin
                timer    <= '0;
                state    <= HUNT;
                busy     <= 1'b0;
                err_flag <= 1'b1;
                err_cnt  <= err_cnt_next;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_data  = cmd_data;
    assign bus.cmd_valid = cmd_valid;
    assign bus.busy      = busy;
    assign bus.err_cnt   = err_cnt;
    assign bus.err_flag  = err_flag;

endmodule
